// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit - iterative radix-2 restoring divider for MIPS DIV / DIVU (EX stage)
//
// Produces the quotient (to LO) and remainder (to HI). The pipeline stalls on
// busy and picks up the result when done pulses.
//
// Optional feature macro: DIV_CANCEL_EN (adds the cancel flush input).
//
// Ports:
//   clk        in   1      rising-edge clock
//   resetn     in   1      asynchronous active-low reset
//   start      in   1      request a division; sampled only in IDLE
//   signed_op  in   1      1 = DIV (two's complement), 0 = DIVU
//   dividend   in   WIDTH  rs operand, sampled with start
//   divisor    in   WIDTH  rt operand, sampled with start
//   cancel     in   1      flush request (DIV_CANCEL_EN builds only)
//   busy       out  1      high while the FSM is not IDLE
//   done       out  1      one-cycle pulse, results valid
//   quotient   out  WIDTH  to LO
//   remainder  out  WIDTH  to HI
//   div_zero   out  1      divisor was zero; valid with done
//   dbg_state  out  2      current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
// Handshake: start is accepted only on an edge where the FSM is IDLE; a start
// seen while busy is ignored. Results are valid in the single cycle done is
// high and then hold until the next FIX cycle updates them.
// Timing: start sampled on edge E0, WIDTH CALC edges, one FIX edge, so done
// is high in the (WIDTH+2)-th cycle counting the start cycle as cycle 1.
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;        // partial remainder, one guard bit
    logic [WIDTH-1:0] quo_q, quo_d;        // |dividend| shifts out, quotient bits shift in
    logic [WIDTH-1:0] dvsr_q, dvsr_d;      // |divisor|
    logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d; // unmodified dividend for the divide-by-zero result
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        dvd_raw_d   = dvd_raw_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        // Bring down the next dividend bit and try subtracting the divisor;
        // a clear guard bit means the trial subtraction did not go negative.
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvsr_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
                    dvsr_d    = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
                    dvd_raw_d = dividend;
                    neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = signed_op & dividend[WIDTH-1];
                end
            end
            CALC: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                if (dvsr_q == '0) begin
                    // Divide by zero: fixed result, no sign correction.
                    quotient_d  = '1;
                    remainder_d = dvd_raw_q;
                    div_zero_d  = 1'b1;
                end else begin
                    // Negating 0x80000000 wraps to itself, which gives the
                    // required MIN_INT / -1 result without a special case.
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    div_zero_d  = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DIV_CANCEL_EN
        // A flush abandons the operation and leaves the visible results alone.
        if (cancel && (state_q != IDLE)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            div_zero_d  = div_zero_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            dvd_raw_q   <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            dvd_raw_q   <= dvd_raw_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit - directed self-checking bench for div_unit (WIDTH = 32).
// Expected results are hand-computed constants. Latency is counted as the
// number of clock edges after the edge that samples start until done is seen
// (33 for WIDTH=32, i.e. done in cycle 34 counting the start cycle as 1).
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    localparam int LAT = 33;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef DIV_CANCEL_EN
        .cancel    (cancel),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Waits for done with a bounded budget; returns the number of edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // ---------------- driver ----------------
    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_div(input string tag, input logic sop,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic ez);
        int n;
        start     = 1'b1;
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = $urandom;   // operands must not be re-sampled
        divisor   = $urandom;
        signed_op = $urandom_range(0, 1);
        check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        check({tag, " no_early_done"}, {31'd0, done}, 32'd0);
        wait_done(n);
        check({tag, " latency"}, 32'(n), 32'(LAT));
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd1);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, " busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, " quotient_hold"}, quotient, eq);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        resetn    = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        cancel    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_div("divu_100_7",   1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          1'b0);
        // back-to-back: started in the first IDLE cycle after done
        run_div("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
        run_div("div_minint",   1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
        run_div("divu_zero",    1'b0, 32'h00001234, 32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1);
        run_div("div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0);
        run_div("divu_max_16",  1'b0, 32'hFFFFFFFF, 32'd16,         32'h0FFFFFFF,   32'h0000000F,   1'b0);
        run_div("div_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0);
        run_div("div_neg_zero", 1'b1, 32'hFFFFFFF9, 32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1);
        run_div("divu_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0);

        // idle outputs hold across several cycles
        repeat (3) @(posedge clk);
        #1;
        check("idle hold quotient", quotient, 32'd1);
        check("idle hold busy", {31'd0, busy}, 32'd0);

        // start re-pulsed in cycle 10 with new operands is ignored
        start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("repulse mid_op_hold", quotient, 32'd1);
        start = 1'b1; signed_op = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check("repulse latency", 32'(n + 9), 32'(LAT));
        check("repulse quotient", quotient, 32'd14);
        check("repulse remainder", remainder, 32'd2);
        @(posedge clk); #1;
        check("repulse idle", {31'd0, busy}, 32'd0);

        // asynchronous reset in the middle of an operation
        start = 1'b1; signed_op = 1'b0; dividend = 32'hFFFFFFFF; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst busy", {31'd0, busy}, 32'd0);
        check("async_rst done", {31'd0, done}, 32'd0);
        check("async_rst quotient", quotient, 32'd0);
        check("async_rst remainder", remainder, 32'd0);
        check("async_rst state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst idle", {31'd0, busy}, 32'd0);
        run_div("post_rst_div", 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'd0, 1'b0);

`ifdef DIV_CANCEL_EN
        // cancel mid-CALC: back to IDLE, no done, outputs unchanged
        start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel busy", {31'd0, busy}, 32'd0);
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) n++;
        end
        check("cancel no_done", 32'(n), 32'd0);
        check("cancel quotient", quotient, 32'h55555555);
        check("cancel remainder", remainder, 32'd0);
        run_div("after_cancel", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
